// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: widths, zero word and the fetch FSM state codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;   // four RAM bytes per instruction

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE     = 2'd0,
    IF_WAIT_GNT = 2'd1,
    IF_RD       = 2'd2,
    IF_HOLD     = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: takes a PC, reads 4 bytes over the shared 8-bit RAM port, presents {inst, pc}.
// Latency: 6 cycles from PC accept to inst_valid_o with an immediate, unbroken grant.
// Backpressure: pc_stall_o high whenever busy; result held in HOLD until IF/ID takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global run enable (0 = pause; flush still acts)
//   pc_i, pc_valid_i      PC from the PC register
//   pc_stall_o            1 while a fetch is in flight or held (state != IDLE)
//   flush_i               abort current fetch, back to IDLE
//   mem_req_o, mem_gnt_i  RAM port request / grant from the arbiter
//   mem_addr_o, mem_din_i byte address out, read data back one cycle later
//   inst_o, inst_pc_o, inst_valid_o, id_stall_i   result handshake to IF/ID
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int INST_W = INST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_din_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              id_stall_i
);

  if_state_e         state;
  logic [2:0]        cnt;       // 0..4: byte address offset / capture step
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              restart;   // a pause hit RD; the read data stream is stale
  logic [1:0]        byte_idx;

  // Data on mem_din_i at step cnt belongs to the address issued at cnt-1.
  // cnt=4 wraps to lane 3 in two bits.
  assign byte_idx   = cnt[1:0] - 2'd1;

  assign pc_stall_o = (state != IF_IDLE);
  assign mem_addr_o = (state == IF_RD) ? pc_q + ADDR_W'(cnt) : ADDR_W'(ZERO_WORD);
  assign inst_o     = inst_q;
  assign inst_pc_o  = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IF_IDLE;
      cnt          <= 3'd0;
      pc_q         <= '0;
      inst_q       <= '0;
      mem_req_o    <= 1'b0;
      inst_valid_o <= 1'b0;
      restart      <= 1'b0;
    end else if (flush_i) begin
      // Redirect wins over everything, including a pause.
      state        <= IF_IDLE;
      cnt          <= 3'd0;
      inst_q       <= '0;
      mem_req_o    <= 1'b0;
      inst_valid_o <= 1'b0;
      restart      <= 1'b0;
    end else if (!rdy) begin
      // Freeze; a read in progress cannot be trusted after the pause.
      if (state == IF_RD) restart <= 1'b1;
    end else begin
      case (state)
        IF_IDLE: begin
          if (pc_valid_i) begin
            pc_q      <= pc_i;
            mem_req_o <= 1'b1;
            state     <= IF_WAIT_GNT;
          end
        end
        IF_WAIT_GNT: begin
          if (mem_gnt_i) begin
            cnt   <= 3'd0;
            state <= IF_RD;
          end
        end
        IF_RD: begin
          if (!mem_gnt_i) begin
            // Lost the port: keep requesting, refetch from byte 0.
            cnt     <= 3'd0;
            restart <= 1'b0;
            state   <= IF_WAIT_GNT;
          end else if (restart) begin
            cnt     <= 3'd0;
            restart <= 1'b0;
          end else begin
            if (cnt != 3'd0) inst_q[{byte_idx, 3'b000} +: 8] <= mem_din_i;
            if (cnt == 3'd4) begin
              cnt          <= 3'd0;
              mem_req_o    <= 1'b0;
              inst_valid_o <= 1'b1;
              state        <= IF_HOLD;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        IF_HOLD: begin
          // Back to IDLE only; the next PC is taken a cycle later.
          if (!id_stall_i) begin
            inst_valid_o <= 1'b0;
            state        <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_valid = 1'b0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        id_stall = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [logic [31:0]];

  always #5 clk = ~clk;

  if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pc_i(pc), .pc_valid_i(pc_valid), .pc_stall_o(pc_stall),
    .flush_i(flush),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_din_i(mem_din),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid), .id_stall_i(id_stall)
  );

  // RAM byte: explicit entries, otherwise a deterministic scramble of the address.
  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [7:0] t;
    if (ram.exists(a)) return ram[a];
    t = a[7:0] * 8'd29;
    return t ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_of(input logic [31:0] p);
    return {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
  endfunction

  // Synchronous-read RAM: data for an address appears the next cycle.
  always @(posedge clk) mem_din <= mb(mem_addr);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs an accepted fetch to completion (grant raised after gd cycles), checks the
  // result, the last four RD addresses and the transfer. Returns cycles accept->valid.
  task automatic wait_done(input logic [31:0] p, input int gd, input logic [31:0] exp_i,
                           input string nm, output int n);
    logic [31:0] hist[$];
    n = 0;
    while (!inst_valid && n < 80) begin
      mem_gnt = (n >= gd);
      hist.push_back(mem_addr);
      step;
      n++;
    end
    chk({nm, "_valid"}, inst_valid, 1'b1);
    chk({nm, "_inst"}, inst, exp_i);
    chk({nm, "_pc"}, inst_pc, p);
    chk({nm, "_req_off"}, mem_req, 1'b0);
    chk({nm, "_hist_len"}, (hist.size() >= 5), 1'b1);
    if (hist.size() >= 5)
      for (int i = 0; i < 4; i++)
        chk({nm, "_addr"}, hist[hist.size() - 5 + i], p + 32'(i));
    id_stall = 1'b0;
    step;
    chk({nm, "_xfer_valid"}, inst_valid, 1'b0);
    chk({nm, "_xfer_stall"}, pc_stall, 1'b0);
  endtask

  task automatic accept(input logic [31:0] p, input string nm);
    pc = p;
    pc_valid = 1'b1;
    chk({nm, "_idle_stall"}, pc_stall, 1'b0);
    step;
    pc_valid = 1'b0;
    chk({nm, "_busy_stall"}, pc_stall, 1'b1);
    chk({nm, "_busy_req"}, mem_req, 1'b1);
  endtask

  typedef struct {
    logic [31:0]      pc;
    int               gd;
    logic [3:0][7:0]  bytes;   // [0] at pc
    logic [31:0]      exp_inst;
    int               exp_lat;
  } vec_t;

  vec_t vecs [4];

  logic [31:0] pend[$];

  initial begin
    int n;
    int xfers;
    int busy_cyc;
    logic seen;
    logic [31:0] held;
    logic was_busy;

    vecs[0] = '{32'h0000_1000, 0, {8'h00, 8'hA0, 8'h05, 8'h13}, 32'h00A0_0513, 6};
    vecs[1] = '{32'h0000_2000, 2, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 32'hDEAD_BEEF, 8};
    vecs[2] = '{32'hFFFF_FFFE, 0, {8'h44, 8'h33, 8'h22, 8'h11}, 32'h4433_2211, 6};
    vecs[3] = '{32'h0000_0003, 1, {8'hC3, 8'h7F, 8'h00, 8'h9A}, 32'hC37F_009A, 7};

    // Reset state
    step;
    step;
    chk("rst_stall", pc_stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, ZERO_WORD);
    chk("rst_addr", mem_addr, ZERO_WORD);
    rst_n = 1'b1;
    rdy = 1'b1;
    step;

    // Table: single fetches, latency, data, address order, wrap
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) ram[vecs[v].pc + 32'(i)] = vecs[v].bytes[i];
      mem_gnt = 1'b0;
      accept(vecs[v].pc, "vec");
      wait_done(vecs[v].pc, vecs[v].gd, vecs[v].exp_inst, "vec", n);
      chk("vec_latency", n, vecs[v].exp_lat);
    end

    // Backpressure in HOLD, then one-cycle bubble before the next accept
    accept(32'h0000_4000, "bp");
    mem_gnt = 1'b1;
    id_stall = 1'b1;
    n = 0;
    while (!inst_valid && n < 80) begin step; n++; end
    held = inst;
    chk("bp_inst", held, exp_of(32'h0000_4000));
    for (int i = 0; i < 3; i++) begin
      step;
      chk("bp_hold_valid", inst_valid, 1'b1);
      chk("bp_hold_inst", inst, held);
      chk("bp_hold_stall", pc_stall, 1'b1);
    end
    id_stall = 1'b0;
    pc = 32'h0000_5000;
    pc_valid = 1'b1;
    step;
    chk("bp_drop_valid", inst_valid, 1'b0);
    chk("bp_bubble", pc_stall, 1'b0);
    step;
    pc_valid = 1'b0;
    chk("bp_next_accept", pc_stall, 1'b1);
    wait_done(32'h0000_5000, 0, exp_of(32'h0000_5000), "bp2", n);

    // Grant loss after the first byte
    mem_gnt = 1'b0;
    accept(32'h0000_6000, "gl");
    mem_gnt = 1'b1;
    step; step; step;          // RD cnt=2, byte 0 captured
    mem_gnt = 1'b0;
    step;
    chk("gl_req_held", mem_req, 1'b1);
    chk("gl_stall", pc_stall, 1'b1);
    step;
    chk("gl_no_valid", inst_valid, 1'b0);
    wait_done(32'h0000_6000, 0, exp_of(32'h0000_6000), "gl", n);

    // Flush at cnt=2 while paused
    accept(32'h0000_7000, "fl");
    mem_gnt = 1'b1;
    step; step; step;
    flush = 1'b1;
    rdy = 1'b0;
    step;
    flush = 1'b0;
    rdy = 1'b1;
    chk("fl_stall", pc_stall, 1'b0);
    chk("fl_req", mem_req, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (inst_valid || pc_stall) seen = 1'b1;
      step;
    end
    chk("fl_quiet", seen, 1'b0);

    // Reset asserted mid-RD
    accept(32'h0000_8000, "rs");
    step; step; step;
    rst_n = 1'b0;
    #1;
    chk("rs_stall", pc_stall, 1'b0);
    chk("rs_req", mem_req, 1'b0);
    chk("rs_addr", mem_addr, ZERO_WORD);
    chk("rs_valid", inst_valid, 1'b0);
    chk("rs_inst", inst, ZERO_WORD);
    chk("rs_ipc", inst_pc, ZERO_WORD);
    step;
    chk("rs_stall_low", pc_stall, 1'b0);
    chk("rs_req_low", mem_req, 1'b0);
    rst_n = 1'b1;
    step;

    // Randomised traffic against a transaction-level model
    xfers = 0;
    busy_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      rdy      = ($urandom_range(0, 99) < 92);
      mem_gnt  = ($urandom_range(0, 99) < 90);
      id_stall = ($urandom_range(0, 99) < 30);
      flush    = ($urandom_range(0, 99) < 2);
      pc_valid = ($urandom_range(0, 99) < 50);
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;

      was_busy = (pend.size() != 0);
      chk("rnd_stall", pc_stall, was_busy);
      chk("rnd_orphan", (inst_valid && !was_busy), 1'b0);
      if (was_busy && inst_valid && rdy && !id_stall && !flush) begin
        chk("rnd_inst", inst, exp_of(pend[0]));
        chk("rnd_pc", inst_pc, pend[0]);
        void'(pend.pop_front());
        xfers++;
      end
      if (flush) pend.delete();
      else if (!was_busy && pc_valid && rdy) pend.push_back(pc);

      busy_cyc = (pend.size() != 0) ? busy_cyc + 1 : 0;
      if (busy_cyc > 400) begin
        chk("rnd_watchdog", busy_cyc, 0);
        busy_cyc = 0;
        pend.delete();
      end
      step;
    end
    chk("rnd_xfers", (xfers > 30), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
